flash_sample_streamer: RTL and testbench

FLASH_SAMPLE_STREAMER -- requirements
Module: flash_sample_streamer

---
 rtl/flash_sample_streamer_pkg.sv | 15 +
 rtl/flash_sample_streamer_if.sv | 20 ++
 rtl/sample_fifo.sv | 51 +++++
 rtl/flash_sample_streamer.sv | 90 +++++++++
 tb/tb_flash_sample_streamer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_sample_streamer_pkg.sv
// Shared audio types and clip constants for the flash-to-codec sample path.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int               FLASH_ADDR_W   = 23;
    localparam logic [22:0]      CLIP_LAST_WORD = 23'h0FFFFF;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2
    } rd_state_e;

endpackage

// File: rtl/flash_sample_streamer_if.sv
// Avalon-MM read-only master bundle between the streamer and the flash controller.
interface flash_sample_streamer_if #(
    parameter int ADDR_W = 23
);
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    modport master (
        output flash_mem_read, flash_mem_address,
        input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read, flash_mem_address,
        output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
    );
endinterface

// File: rtl/sample_fifo.sv
// Power-of-two synchronous FIFO; pushes when full and pops when empty are dropped.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/flash_sample_streamer.sv
// Prefetches 32-bit words from flash over Avalon-MM and streams them out as
// two signed 16-bit samples each (low half first).
module flash_sample_streamer
    import audio_pkg::*;
#(
    parameter int                ADDR_W    = FLASH_ADDR_W,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(CLIP_LAST_WORD)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    flash_sample_streamer_if.master   fm,
    output sample_t                   sample,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      wrapped
);
    localparam int CW = $clog2(DEPTH) + 1;

    rd_state_e         state_q;
    logic              read_q, wrapped_q, half_q;
    logic [ADDR_W-1:0] addr_q;

    logic [CW-1:0]     fifo_count;
    logic [31:0]       fifo_word;
    logic              fifo_empty, fifo_full;
    logic              outstanding, space_ok, push, pop, xfer;

    // A read is only launched when its word is guaranteed a FIFO slot on arrival.
    assign outstanding = (state_q != RD_IDLE);
    assign space_ok    = !fifo_full && ((fifo_count + CW'(outstanding)) < CW'(DEPTH));
    assign push        = (state_q == RD_WAIT) && fm.flash_mem_readdatavalid;
    assign xfer        = sample_valid && sample_ready;
    assign pop         = xfer && half_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            read_q    <= 1'b0;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            wrapped_q <= 1'b0;
            case (state_q)
                RD_IDLE: if (enable && space_ok) begin
                    state_q <= RD_REQ;
                    read_q  <= 1'b1;
                end
                // Once issued, the request stays up regardless of enable.
                RD_REQ: if (!fm.flash_mem_waitrequest) begin
                    state_q   <= RD_WAIT;
                    read_q    <= 1'b0;
                    wrapped_q <= (addr_q == LAST_WORD);
                    addr_q    <= (addr_q == LAST_WORD) ? '0 : addr_q + 1'b1;
                end
                RD_WAIT: if (fm.flash_mem_readdatavalid)
                    state_q <= RD_IDLE;
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            half_q <= 1'b0;
        else if (xfer)
            half_q <= ~half_q;
    end

    sample_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (fm.flash_mem_readdata),
        .pop_i   (pop),
        .dout_o  (fifo_word),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign fm.flash_mem_read    = read_q;
    assign fm.flash_mem_address = addr_q;
    assign wrapped              = wrapped_q;
    assign sample_valid         = !fifo_empty;
    // Forced to zero on empty so a bubble never exposes a stale word.
    assign sample = fifo_empty ? sample_t'(0)
                  : (half_q ? sample_t'(fifo_word[31:16]) : sample_t'(fifo_word[15:0]));
endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed bench: table of read/unpack vectors plus hand-written corner sequences.
module tb_flash_sample_streamer;
    import audio_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    enable = 1'b0;
    logic    sample_ready = 1'b0;
    sample_t sample;
    logic    sample_valid, wrapped;

    flash_sample_streamer_if #(.ADDR_W(23)) fm ();

    flash_sample_streamer #(.ADDR_W(23), .DEPTH(4), .LAST_WORD(23'd5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fm           (fm),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .wrapped      (wrapped)
    );

    always #5 clk = ~clk;

    int          total = 0, passed = 0;
    int          accept_cnt = 0, wrap_cnt = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [22:0] last_addr;

    // Handshakes complete at the following rising edge, so observe mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid && sample_ready) got_q.push_back(sample);
            if (fm.flash_mem_read && !fm.flash_mem_waitrequest) accept_cnt++;
            if (wrapped) wrap_cnt++;
        end
    end

    typedef struct {
        logic [31:0] word;
        int          lat;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_read();
        int n = 0;
        while (fm.flash_mem_read !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("read_request", 32'(fm.flash_mem_read), 32'd1);
        last_addr = fm.flash_mem_address;
    endtask

    task automatic serve(input logic [31:0] word, input int lat);
        wait_read();
        tick();
        check("read_drop", 32'(fm.flash_mem_read), 32'd0);
        repeat (lat - 1) tick();
        fm.flash_mem_readdata      = word;
        fm.flash_mem_readdatavalid = 1'b1;
        tick();
        fm.flash_mem_readdatavalid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (12) tick();
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, {16'h0, got_q[i]}, {16'h0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int acc0, wrap0;
        logic stable;
        logic [22:0] a0;

        tbl[0] = '{32'hFFFE_0003, 2, 16'h0003, 16'hFFFE};
        tbl[1] = '{32'h8000_7FFF, 3, 16'h7FFF, 16'h8000};
        tbl[2] = '{32'h1234_ABCD, 2, 16'hABCD, 16'h1234};
        tbl[3] = '{32'h0000_FFFF, 4, 16'hFFFF, 16'h0000};

        fm.flash_mem_waitrequest   = 1'b0;
        fm.flash_mem_readdata      = 32'h0;
        fm.flash_mem_readdatavalid = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_read",    32'(fm.flash_mem_read), 32'd0);
        check("rst_addr",    32'(fm.flash_mem_address), 32'd0);
        check("rst_valid",   32'(sample_valid), 32'd0);
        check("rst_wrapped", 32'(wrapped), 32'd0);
        check("rst_sample",  {16'h0, sample}, 32'd0);
        rst_n = 1'b1;

        // Table: one read per vector, FIFO empty before each word lands
        acc0 = accept_cnt;
        enable = 1'b1;
        sample_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_read();
            check("tbl_addr", 32'(last_addr), i);
            tick();
            check("tbl_read_drop", 32'(fm.flash_mem_read), 32'd0);
            repeat (tbl[i].lat - 1) tick();
            check("tbl_bubble", 32'(sample_valid), 32'd0);
            fm.flash_mem_readdata      = tbl[i].word;
            fm.flash_mem_readdatavalid = 1'b1;
            tick();
            fm.flash_mem_readdatavalid = 1'b0;
            check("tbl_latency_valid", 32'(sample_valid), 32'd1);
            check("tbl_low_first", {16'h0, sample}, {16'h0, tbl[i].lo});
            exp_q.push_back(tbl[i].lo);
            exp_q.push_back(tbl[i].hi);
        end
        enable = 1'b0;
        drain("tbl_stream");
        check("tbl_accepts", accept_cnt - acc0, 32'd4);
        check("tbl_addr_after", 32'(fm.flash_mem_address), 32'd4);

        // Waitrequest stall: request and address held, enable dropped mid-request
        acc0 = accept_cnt;
        fm.flash_mem_waitrequest = 1'b1;
        enable = 1'b1;
        wait_read();
        a0 = last_addr;
        check("stall_addr", 32'(a0), 32'd4);
        enable = 1'b0;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (fm.flash_mem_read !== 1'b1 || fm.flash_mem_address !== a0) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        fm.flash_mem_waitrequest = 1'b0;
        tick();
        check("stall_read_drop", 32'(fm.flash_mem_read), 32'd0);
        check("stall_addr_inc", 32'(fm.flash_mem_address), 32'd5);
        tick();
        fm.flash_mem_readdata      = 32'hCAFE_BEEF;
        fm.flash_mem_readdatavalid = 1'b1;
        tick();
        fm.flash_mem_readdatavalid = 1'b0;
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hCAFE);
        drain("stall_stream");
        check("stall_accepts", accept_cnt - acc0, 32'd1);

        // Wrap at LAST_WORD
        wrap0 = wrap_cnt;
        enable = 1'b1;
        serve(32'h0BAD_F00D, 2);
        check("wrap_last_addr", 32'(last_addr), 32'd5);
        serve(32'h1111_2222, 2);
        enable = 1'b0;
        check("wrap_next_addr", 32'(last_addr), 32'd0);
        exp_q.push_back(16'hF00D);
        exp_q.push_back(16'h0BAD);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h1111);
        drain("wrap_stream");
        check("wrap_pulses", wrap_cnt - wrap0, 32'd1);

        // Backpressure: FIFO fills to DEPTH, then drains in order
        acc0 = accept_cnt;
        sample_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve({16'(2 * i + 2), 16'(2 * i + 1)}, 2);
            if (i == 0) check("bp_first_addr", 32'(last_addr), 32'd1);
        end
        tick();
        check("bp_held_sample", {16'h0, sample}, 32'd1);
        repeat (10) tick();
        check("bp_accepts", accept_cnt - acc0, 32'd4);
        check("bp_read_idle", 32'(fm.flash_mem_read), 32'd0);
        check("bp_valid", 32'(sample_valid), 32'd1);
        check("bp_sample_stable", {16'h0, sample}, 32'd1);
        enable = 1'b0;
        sample_ready = 1'b1;
        for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
        drain("bp_stream");

        // Enable dropped during WAIT_DATA: data still captured, no new reads
        acc0 = accept_cnt;
        enable = 1'b1;
        wait_read();
        tick();
        enable = 1'b0;
        tick();
        fm.flash_mem_readdata      = 32'h5555_AAAA;
        fm.flash_mem_readdatavalid = 1'b1;
        tick();
        fm.flash_mem_readdatavalid = 1'b0;
        check("endrop_valid", 32'(sample_valid), 32'd1);
        check("endrop_sample", {16'h0, sample}, 32'h0000_AAAA);
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'h5555);
        drain("endrop_stream");
        check("endrop_accepts", accept_cnt - acc0, 32'd1);
        check("endrop_empty", 32'(sample_valid), 32'd0);
        check("endrop_no_stale", {16'h0, sample}, 32'd0);
        check("endrop_read_idle", 32'(fm.flash_mem_read), 32'd0);

        // Reset during WAIT_DATA, then a stray readdatavalid
        enable = 1'b1;
        wait_read();
        tick();
        rst_n = 1'b0;
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_read", 32'(fm.flash_mem_read), 32'd0);
        check("midrst_addr", 32'(fm.flash_mem_address), 32'd0);
        fm.flash_mem_readdata      = 32'hDEAD_BEEF;
        fm.flash_mem_readdatavalid = 1'b1;
        tick();
        fm.flash_mem_readdatavalid = 1'b0;
        tick();
        check("midrst_valid", 32'(sample_valid), 32'd0);
        check("midrst_sample", {16'h0, sample}, 32'd0);
        drain("midrst_stream");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
